seg7_scan: RTL and testbench

- Parametrised, time-multiplexed driver for a bank of common-anode/cathode 7-segment digits.
- Takes a packed hex word and per-digit decimal-point and blank masks.
- Scans one digit at a time at a programmable rate and drives a shared segment bus plus one-hot digit enables.
- Sits between the datapath (counters, display registers) and the board's HEX/AN pins. Inputs are shadow-latched once per frame so the display never tears.

---
 rtl/seg7_scan_if.sv | 24 ++
 rtl/seg7_scan.sv | 148 ++++++++++++++
 tb/tb_seg7_scan.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Display bus between a datapath and the seg7_scan driver: scan control and
// value inputs toward the driver, segment/digit pins and frame strobe back.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  EN;
  logic [4*DIGITS-1:0]   DIN;
  logic [DIGITS-1:0]     DP_IN;
  logic [DIGITS-1:0]     BLANK;
  logic [6:0]            HEX;
  logic                  DP;
  logic [DIGITS-1:0]     AN;
  logic                  FRAME;

  modport master (
    output EN, DIN, DP_IN, BLANK,
    input  HEX, DP, AN, FRAME
  );

  modport slave (
    input  EN, DIN, DP_IN, BLANK,
    output HEX, DP, AN, FRAME
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scanner: one digit lit per SCAN_DIV cycles,
// inputs shadow-latched at each frame boundary so a frame never mixes values.
module seg7_scan #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit LZB        = 1'b0
) (
  input logic        CLK,
  input logic        RST,
  seg7_scan_if.slave bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        HEX_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h27;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      4'hF: seg_decode = 7'h71;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_din;
  logic [DIGITS-1:0]   r_dp_in;
  logic [DIGITS-1:0]   r_blank;
  logic                r_frame;
  logic [6:0]          r_hex;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_tick;
  logic                w_frame_edge;
  logic [3:0]          w_nib;
  logic                w_dp_sel;
  logic                w_blank_sel;
  logic                w_zero_run;
  logic                w_lz_dark;
  logic                w_dark;
  logic [DIGITS-1:0]   w_an_hi;

  assign w_tick       = bus.EN && (r_cnt == CNT_LAST);
  assign w_frame_edge = w_tick && (r_idx == IDX_LAST);

  // Walk from the top digit down so w_zero_run holds "this and all higher nibbles are zero".
  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_zero_run  = 1'b1;
    w_lz_dark   = 1'b0;
    w_an_hi     = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_din[4*i +: 4] == 4'h0);
      if (IW'(i) == r_idx) begin
        w_nib       = r_din[4*i +: 4];
        w_dp_sel    = r_dp_in[i];
        w_blank_sel = r_blank[i];
        w_lz_dark   = (i > 0) && w_zero_run;
        w_an_hi[i]  = 1'b1;
      end else begin
        w_an_hi[i]  = 1'b0;
      end
    end
    w_dark = w_blank_sel || (LZB && w_lz_dark);
  end

  // Prescaler and digit index; both freeze while EN is low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else if (bus.EN) begin
      r_cnt <= r_cnt + 1'b1;
      r_idx <= r_idx;
    end else begin
      r_cnt <= r_cnt;
      r_idx <= r_idx;
    end
  end

  // Shadow registers reload only at a frame boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_din   <= '0;
      r_dp_in <= '0;
      r_blank <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_frame_edge;
      if (w_frame_edge) begin
        r_din   <= bus.DIN;
        r_dp_in <= bus.DP_IN;
        r_blank <= bus.BLANK;
      end else begin
        r_din   <= r_din;
        r_dp_in <= r_dp_in;
        r_blank <= r_blank;
      end
    end
  end

  // Pin registers; polarity applied by XOR with the off level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hex <= HEX_OFF;
      r_dp  <= DP_OFF;
      r_an  <= AN_OFF;
    end else if (!bus.EN) begin
      r_hex <= HEX_OFF;
      r_dp  <= DP_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_hex <= (w_dark ? 7'h00 : seg_decode(w_nib)) ^ HEX_OFF;
      r_dp  <= (w_dp_sel && !w_dark) ^ DP_OFF;
      r_an  <= w_an_hi ^ AN_OFF;
    end
  end

  assign bus.HEX   = r_hex;
  assign bus.DP    = r_dp;
  assign bus.AN    = r_an;
  assign bus.FRAME = r_frame;
endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: three instances (4-digit scan/LZB, 1-digit
// decode sweep, 8-digit fast scan) checked against hand-computed expectations.
module tb_seg7_scan;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] an;
    logic [6:0] hex;
    logic       dp;
    logic       fr;
  } exp_t;

  exp_t sb[$];

  seg7_scan_if #(.DIGITS(4)) bus_a ();
  seg7_scan_if #(.DIGITS(1)) bus_b ();
  seg7_scan_if #(.DIGITS(8)) bus_c ();

  seg7_scan #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0), .LZB(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .bus(bus_a));
  seg7_scan #(.DIGITS(1), .SCAN_DIV(1), .ACTIVE_LOW(1'b1), .LZB(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .bus(bus_b));
  seg7_scan #(.DIGITS(8), .SCAN_DIV(1), .ACTIVE_LOW(1'b1), .LZB(1'b0)) dut_c (
    .CLK(CLK), .RST(RST), .bus(bus_c));

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push(input int c, input int sel, input logic [7:0] an,
                      input logic [6:0] hex, input logic dp, input logic fr);
    exp_t e;
    e.cyc = c; e.sel = sel; e.an = an; e.hex = hex; e.dp = dp; e.fr = fr;
    sb.push_back(e);
  endtask

  // One regular 4-digit frame of dut_a; h packs {d3,d2,d1,d0} segment codes.
  task automatic frame_a(input int s, input logic [27:0] h, input logic [3:0] dps);
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 4; k++)
        push(s + 4*d + k, 0, 8'(1 << d), h[7*d +: 7], dps[d], (d == 3) && (k == 3));
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  // Monitor: pops every expectation due now (cyc == -1 means immediate) and compares.
  initial begin
    exp_t e;
    logic [7:0] an;
    logic [6:0] hex;
    logic dp, fr;
    string nm;
    forever begin
      @(negedge CLK or chk_ev);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.sel)
          0: begin an = {4'b0000, bus_a.AN}; hex = bus_a.HEX; dp = bus_a.DP; fr = bus_a.FRAME; nm = "dut_a"; end
          1: begin an = {7'b0000000, bus_b.AN}; hex = bus_b.HEX; dp = bus_b.DP; fr = bus_b.FRAME; nm = "dut_b"; end
          default: begin an = bus_c.AN; hex = bus_c.HEX; dp = bus_c.DP; fr = bus_c.FRAME; nm = "dut_c"; end
        endcase
        checks = checks + 1;
        if (e.cyc >= 0 && e.cyc != cyc) begin
          errors = errors + 1;
          $display("FAIL %s stale expectation for cyc %0d seen at cyc %0d", nm, e.cyc, cyc);
        end else if (an !== e.an || hex !== e.hex || dp !== e.dp || fr !== e.fr) begin
          errors = errors + 1;
          $display("FAIL %s cyc=%0d got an=%h hex=%h dp=%b frame=%b want an=%h hex=%h dp=%b frame=%b",
                   nm, e.cyc, an, hex, dp, fr, e.an, e.hex, e.dp, e.fr);
        end
      end
    end
  end

  initial begin
    int c0, c1, c2, c3, idx, val;
    logic [3:0] nv;
    bus_a.EN = 1'b0; bus_a.DIN = '0; bus_a.DP_IN = '0; bus_a.BLANK = '0;
    bus_b.EN = 1'b0; bus_b.DIN = '0; bus_b.DP_IN = '0; bus_b.BLANK = '0;
    bus_c.EN = 1'b0; bus_c.DIN = '0; bus_c.DP_IN = '0; bus_c.BLANK = '0;

    #1 RST = 1'b1;
    #1;
    push(-1, 0, 8'h00, 7'h00, 1'b0, 1'b0);
    push(-1, 1, 8'h01, 7'h7F, 1'b1, 1'b0);
    push(-1, 2, 8'hFF, 7'h7F, 1'b1, 1'b0);
    -> chk_ev;
    #1;
    @(negedge CLK);
    @(negedge CLK);

    // dut_a: scan order, tear-free load, LZB/DP/BLANK, EN freeze
    RST = 1'b0;
    c0 = cyc;
    bus_a.EN = 1'b1; bus_a.DIN = 16'h1234;
    frame_a(c0 + 1,  {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
    frame_a(c0 + 17, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);
    frame_a(c0 + 33, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0000);
    frame_a(c0 + 49, {7'h00, 7'h00, 7'h66, 7'h3F}, 4'b0010);
    frame_a(c0 + 65, {7'h00, 7'h00, 7'h66, 7'h00}, 4'b0010);
    for (int k = 81; k <= 84; k++) push(c0 + k, 0, 8'h01, 7'h3F, 1'b0, 1'b0);
    for (int k = 85; k <= 86; k++) push(c0 + k, 0, 8'h02, 7'h00, 1'b0, 1'b0);
    for (int k = 87; k <= 90; k++) push(c0 + k, 0, 8'h00, 7'h00, 1'b0, 1'b0);
    for (int k = 91; k <= 92; k++) push(c0 + k, 0, 8'h02, 7'h00, 1'b0, 1'b0);
    for (int k = 93; k <= 96; k++) push(c0 + k, 0, 8'h04, 7'h00, 1'b0, 1'b0);
    for (int k = 97; k <= 100; k++) push(c0 + k, 0, 8'h08, 7'h00, 1'b0, k == 100);
    wait_until(c0 + 26); bus_a.DIN = 16'hABCD;
    wait_until(c0 + 40); bus_a.DIN = 16'h0040; bus_a.DP_IN = 4'b0010;
    wait_until(c0 + 56); bus_a.BLANK = 4'b0001;
    wait_until(c0 + 72); bus_a.DIN = 16'h0000; bus_a.BLANK = 4'b0000;
    wait_until(c0 + 86); bus_a.EN = 1'b0;
    wait_until(c0 + 90); bus_a.EN = 1'b1;
    wait_until(c0 + 100);

    // dut_b: decode sweep, one frame per cycle
    c1 = cyc;
    for (int v = 0; v < 16; v++) begin
      wait_until(c1 + 3*v);
      nv = v[3:0];
      bus_b.EN = 1'b1; bus_b.DIN = nv; bus_b.DP_IN = nv[0];
      push(c1 + 3*v + 2, 1, 8'h00, ~SEG[v], ~nv[0], 1'b1);
      push(c1 + 3*v + 3, 1, 8'h00, ~SEG[v], ~nv[0], 1'b1);
    end
    wait_until(c1 + 48);
    bus_b.EN = 1'b0;

    // dut_c: 8 digits rotating every cycle, frame every 8 cycles
    c2 = cyc;
    bus_c.EN = 1'b1; bus_c.DIN = 32'h76543210;
    for (int r = 1; r <= 16; r++) begin
      idx = (r - 1) % 8;
      val = (r <= 8) ? 0 : idx;
      push(c2 + r, 2, ~(8'h01 << idx), ~SEG[val], 1'b1, (r % 8) == 0);
    end
    wait_until(c2 + 16);

    // asynchronous reset between edges while dut_c shows FRAME
    #2 RST = 1'b1;
    #1;
    push(-1, 0, 8'h00, 7'h00, 1'b0, 1'b0);
    push(-1, 1, 8'h01, 7'h7F, 1'b1, 1'b0);
    push(-1, 2, 8'hFF, 7'h7F, 1'b1, 1'b0);
    -> chk_ev;
    #1;
    @(negedge CLK);
    RST = 1'b0;
    c3 = cyc;
    for (int r = 1; r <= 16; r++) begin
      push(c3 + r, 0, 8'(1 << ((r - 1) / 4)), (r <= 4) ? 7'h3F : 7'h00, 1'b0, r == 16);
      if (r <= 8) push(c3 + r, 2, ~(8'h01 << (r - 1)), 7'h40, 1'b1, r == 8);
    end
    wait_until(c3 + 16);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb.size() > 0) begin
      $display("FAIL drain %0d expectations never compared", sb.size());
      errors = errors + sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
